bcd_display_scanner: RTL and testbench

- Decoder-side counterpart of the keypad BCD encoder and shift register array.
- Latches a snapshot of up to eight stored BCD digits and time-multiplexes them onto a single active-low 7-segment bus with one-hot active-low digit enables.
- Sits downstream of the shift register array, driving the board's 8-digit display.
- Contains a prescaler, a scan counter, a snapshot register and a registered segment decoder.

---
 rtl/bcd_display_scanner.sv | 115 +++++++++++
 tb/tb_bcd_display_scanner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_scanner
//  Purpose  : Latches a snapshot of up to eight BCD digits and scans them
//             onto a single active-low 7-segment bus. The digit enables are
//             active-low and one-hot. Each digit stays on for PRESCALE
//             cycles. Digits at or above the captured count stay dark.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             load       - capture strobe for digits_in / count_in
//             digits_in  - eight BCD nibbles, [3:0] = digit 0
//             count_in   - number of valid digits; values above 8 become 8
//             seg        - segments {g,f,e,d,c,b,a}, active-low, registered
//             an         - digit enables, active-low one-hot, registered
//             frame_done - one-cycle pulse aligned with digit 0 of a new frame
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] digits_in,
    input  logic [3:0]  count_in,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] C_TC_VAL = CNT_W'(PRESCALE - 1);

    // Active-low 7-segment decode, {g,f,e,d,c,b,a}. Non-BCD codes show a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_dig_q, snap_dig_d;
    logic [3:0]       snap_cnt_q, snap_cnt_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       an_q, an_d;
    logic             wrap_q, wrap_d;
    logic             fdone_q;
    logic             w_tc;
    logic             w_active;
    logic [3:0]       w_digit;

    assign w_tc     = (presc_q == C_TC_VAL);
    assign w_active = ({1'b0, idx_q} < snap_cnt_q);
    assign w_digit  = snap_dig_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        presc_d    = w_tc ? '0 : presc_q + 1'b1;
        idx_d      = w_tc ? idx_q + 3'd1 : idx_q;
        snap_dig_d = snap_dig_q;
        snap_cnt_d = snap_cnt_q;
        if (load) begin
            snap_dig_d = digits_in;
            snap_cnt_d = (count_in > 4'd8) ? 4'd8 : count_in;
        end
        // The output stage follows the current index and snapshot. A new load
        // reaches the outputs one cycle after it is captured.
        seg_d  = w_active ? f_decode(w_digit) : 7'h7F;
        an_d   = w_active ? ~(8'b1 << idx_q) : 8'hFF;
        // wrap_q marks the edge where the index goes 7->0. The outputs lag
        // the index by one cycle, so frame_done takes one more register stage.
        // This makes it coincide with the first display of digit 0.
        wrap_d = w_tc && (idx_q == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= 3'd0;
            snap_dig_q <= 32'd0;
            snap_cnt_q <= 4'd0;
            seg_q      <= 7'h7F;
            an_q       <= 8'hFF;
            wrap_q     <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_cnt_q <= snap_cnt_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            wrap_q     <= wrap_d;
            fdone_q    <= wrap_q;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_display_scanner
//  Purpose  : Directed self-checking bench for bcd_display_scanner with
//             PRESCALE = 4. Expected segment patterns are hand-decoded tables.
//             The expected scan position comes from the cycle count since
//             reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int P = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] digits_in;
    logic [3:0]  count_in;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    int n_cmp;
    int n_err;
    int k;             // rising edges since reset release
    int exp_cnt;
    logic [6:0] exp_tab [8];

    bcd_display_scanner #(.PRESCALE(P), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .count_in   (count_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @k=%0d: got %0h, wanted %0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic set_tab(input logic [6:0] t0, t1, t2, t3, t4, t5, t6, t7);
        exp_tab[0] = t0; exp_tab[1] = t1; exp_tab[2] = t2; exp_tab[3] = t3;
        exp_tab[4] = t4; exp_tab[5] = t5; exp_tab[6] = t6; exp_tab[7] = t7;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [3:0] c);
        digits_in = d;
        count_in  = c;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Outputs after edge k show the index reached after k-1 edges.
    // frame_done coincides with digit 0 of every frame after the first.
    task automatic run_chk(input string tag, input int n);
        int sh;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_fd;
        for (int c = 0; c < n; c++) begin
            tick();
            sh    = ((k - 1) / P) % 8;
            e_an  = (sh < exp_cnt) ? ~(8'b1 << sh) : 8'hFF;
            e_seg = (sh < exp_cnt) ? exp_tab[sh] : 7'h7F;
            e_fd  = (k > 1) && (((k - 1) % (8 * P)) == 0);
            chk({tag, ".an"},  {24'd0, an},  {24'd0, e_an});
            chk({tag, ".seg"}, {25'd0, seg}, {25'd0, e_seg});
            chk({tag, ".fd"},  {31'd0, frame_done}, {31'd0, e_fd});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.seg", {25'd0, seg}, 32'h7F);
        chk("rst.an",  {24'd0, an},  32'hFF);
        chk("rst.fd",  {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; k = 0;
        load = 1'b0; digits_in = 32'd0; count_in = 4'd0; rst_n = 1'b1;
        exp_cnt = 0;
        set_tab(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        @(negedge clk);
        do_reset();

        // Before any load the display is dark, but frames still complete.
        run_chk("blank0", 36);

        // Digits 2,1,9,3,4,5,8,1 from nibble [3:0] upward.
        set_tab(7'h24, 7'h79, 7'h10, 7'h30, 7'h19, 7'h12, 7'h00, 7'h79);
        do_load(32'h1854_3912, 4'd8);
        exp_cnt = 8;
        run_chk("full8", 66);

        // Three valid digits: 2,1,9. Digits 3..7 stay blanked.
        set_tab(7'h24, 7'h79, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        do_load(32'h0000_0912, 4'd3);
        exp_cnt = 3;
        run_chk("cnt3", 34);

        // A count of 12 saturates to 8.
        set_tab(7'h24, 7'h79, 7'h10, 7'h30, 7'h19, 7'h12, 7'h00, 7'h79);
        do_load(32'h1854_3912, 4'd12);
        exp_cnt = 8;
        run_chk("cnt12", 34);

        // A non-BCD value in digit 5 shows a dash while an = DF.
        set_tab(7'h24, 7'h79, 7'h10, 7'h30, 7'h19, 7'h3F, 7'h00, 7'h79);
        do_load(32'h18B4_3912, 4'd8);
        run_chk("nonbcd", 34);

        // Load on a terminal-count cycle changes digit 1 from 1 to 7.
        set_tab(7'h24, 7'h79, 7'h10, 7'h30, 7'h19, 7'h12, 7'h00, 7'h79);
        do_load(32'h1854_3912, 4'd8);
        run_chk("pre_tc", 2);
        while ((k % P) != (P - 1)) run_chk("pre_tc", 1);
        do_load(32'h1854_3972, 4'd8);
        exp_tab[1] = 7'h78;
        run_chk("tc_load", 40);

        // Reset in the middle of a frame, between edges, while the index is 5.
        while (((k / P) % 8) != 5) run_chk("pre_rst", 1);
        #2;
        do_reset();
        exp_cnt = 0;
        run_chk("post_rst", 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, wanted completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
